// File: rtl/move_sched.sv
// -----------------------------------------------------------------------------
// move_sched: sequencer/arbiter in front of the move checker.
//
// Collects block-appear, gravity-tick and user-move requests, chooses one at a
// time by fixed priority (appear > gravity > user), starts the checker with the
// chosen move code, waits for its verdict and turns that verdict into a single
// result: commit (apply the move), lock (block landed) or game-over (spawn is
// blocked). A checker that never answers is abandoned after TIMEOUT_CYC cycles.
//
// Ports:
//   clk_i           system clock
//   rst_n_i         synchronous active-low reset
//   appear_req_i    pulse: new block placed, check its spawn position
//   gravity_tick_i  pulse: periodic fall step (issued as MOVE_DOWN)
//   user_valid_i    user move request valid
//   user_move_i     user move code (left/right/down/rotate)
//   user_ready_o    user request accepted when valid && ready
//   chk_run_o       one-cycle start pulse to the checker
//   chk_move_o      move code to the checker, held until the next selection
//   chk_done_i      checker done pulse
//   chk_can_move_i  checker verdict, valid with done
//   commit_o        pulse: apply commit_move_o
//   commit_move_o   move code being committed
//   lock_o          pulse: downward move rejected, block landed
//   game_over_o     sticky: spawn check rejected; only reset clears it
//   timeout_o       pulse: checker did not answer in time
//   busy_o          sequencer is not idle
//
// Optional build macro MOVE_SCHED_STATS_EN adds saturating 16-bit counters:
//   stat_commit_o   number of commits
//   stat_reject_o   number of can=0 verdicts
//   stat_timeout_o  number of timeouts
// -----------------------------------------------------------------------------

`ifndef MOVE_LEFT
`define MOVE_LEFT   3'd1
`endif
`ifndef MOVE_RIGHT
`define MOVE_RIGHT  3'd2
`endif
`ifndef MOVE_ROTATE
`define MOVE_ROTATE 3'd3
`endif
`ifndef MOVE_DOWN
`define MOVE_DOWN   3'd4
`endif
`ifndef MOVE_APPEAR
`define MOVE_APPEAR 3'd5
`endif

module move_sched #(
    parameter int TIMEOUT_CYC = 32,
    parameter int TIMEOUT_W   = 6
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        appear_req_i,
    input  logic        gravity_tick_i,
    input  logic        user_valid_i,
    input  logic [2:0]  user_move_i,
    output logic        user_ready_o,
    output logic        chk_run_o,
    output logic [2:0]  chk_move_o,
    input  logic        chk_done_i,
    input  logic        chk_can_move_i,
    output logic        commit_o,
    output logic [2:0]  commit_move_o,
    output logic        lock_o,
    output logic        game_over_o,
    output logic        timeout_o,
`ifdef MOVE_SCHED_STATS_EN
    output logic [15:0] stat_commit_o,
    output logic [15:0] stat_reject_o,
    output logic [15:0] stat_timeout_o,
`endif
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_RESULT
    } state_t;

    // What the RESULT cycle has to announce.
    typedef enum logic [2:0] {
        R_NONE,
        R_COMMIT,
        R_LOCK,
        R_OVER,
        R_DROP,
        R_TIMEOUT
    } result_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    result_t              res_q, res_d;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [2:0]           move_q;
    logic [2:0]           commit_move_q;
    logic                 appear_pend_q;
    logic                 grav_pend_q;
    logic                 game_over_q;

    logic                 appear_any;
    logic                 grav_any;
    logic                 sel;
    logic                 sel_appear;
    logic                 sel_grav;
    logic [2:0]           sel_code;
    logic                 over_set;

    // A request counts as present if it is pending or arriving this cycle.
    assign appear_any = appear_pend_q | appear_req_i;
    assign grav_any   = grav_pend_q | gravity_tick_i;

    assign user_ready_o = (state_q == S_IDLE) && !game_over_q && !appear_any && !grav_any;

    // -------------------------------------------------------------------------
    // Next-state / selection logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        res_d      = res_q;
        sel        = 1'b0;
        sel_appear = 1'b0;
        sel_grav   = 1'b0;
        sel_code   = move_q;

        case (state_q)
            S_IDLE: begin
                if (!game_over_q) begin
                    if (appear_any) begin
                        sel        = 1'b1;
                        sel_appear = 1'b1;
                        sel_code   = `MOVE_APPEAR;
                    end else if (grav_any) begin
                        sel      = 1'b1;
                        sel_grav = 1'b1;
                        sel_code = `MOVE_DOWN;
                    end else if (user_valid_i) begin
                        sel      = 1'b1;
                        sel_code = user_move_i;
                    end
                end
                if (sel) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Done takes precedence over the timeout limit in the same cycle.
                if (chk_done_i) begin
                    state_d = S_RESULT;
                    if (chk_can_move_i) begin
                        res_d = R_COMMIT;
                    end else if (move_q == `MOVE_DOWN) begin
                        res_d = R_LOCK;
                    end else if (move_q == `MOVE_APPEAR) begin
                        res_d = R_OVER;
                    end else begin
                        res_d = R_DROP;
                    end
                end else if (cnt_q == WAIT_LIMIT) begin
                    state_d = S_RESULT;
                    res_d   = R_TIMEOUT;
                end
            end

            S_RESULT: begin
                state_d = S_IDLE;
                res_d   = R_NONE;
            end

            default: begin
                state_d = S_IDLE;
                res_d   = R_NONE;
            end
        endcase
    end

    // Game-over becomes visible together with the RESULT cycle.
    assign over_set = (state_q == S_WAIT) && (state_d == S_RESULT) && (res_d == R_OVER);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            res_q         <= R_NONE;
            cnt_q         <= '0;
            move_q        <= 3'd0;
            commit_move_q <= 3'd0;
            appear_pend_q <= 1'b0;
            grav_pend_q   <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            res_q <= res_d;

            // Counter is zero on WAIT entry and advances once per WAIT cycle.
            if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            if (sel) begin
                move_q <= sel_code;
            end

            if ((state_q == S_WAIT) && chk_done_i && chk_can_move_i) begin
                commit_move_q <= move_q;
            end

            if (over_set) begin
                game_over_q <= 1'b1;
            end

            // Repeated pulses simply re-set an already-set flag (merged).
            if (game_over_q || over_set) begin
                appear_pend_q <= 1'b0;
                grav_pend_q   <= 1'b0;
            end else begin
                appear_pend_q <= appear_any & ~sel_appear;
                grav_pend_q   <= grav_any & ~sel_grav;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign chk_run_o     = (state_q == S_RUN);
    assign chk_move_o    = move_q;
    assign commit_o      = (state_q == S_RESULT) && (res_q == R_COMMIT);
    assign commit_move_o = commit_move_q;
    assign lock_o        = (state_q == S_RESULT) && (res_q == R_LOCK);
    assign timeout_o     = (state_q == S_RESULT) && (res_q == R_TIMEOUT);
    assign game_over_o   = game_over_q;
    assign busy_o        = (state_q != S_IDLE);

`ifdef MOVE_SCHED_STATS_EN
    logic        reject_ev;
    logic [15:0] stat_commit_q;
    logic [15:0] stat_reject_q;
    logic [15:0] stat_timeout_q;

    assign reject_ev = (state_q == S_RESULT) &&
                       ((res_q == R_LOCK) || (res_q == R_OVER) || (res_q == R_DROP));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stat_commit_q  <= 16'd0;
            stat_reject_q  <= 16'd0;
            stat_timeout_q <= 16'd0;
        end else begin
            if (commit_o && (stat_commit_q != 16'hFFFF)) begin
                stat_commit_q <= stat_commit_q + 16'd1;
            end
            if (reject_ev && (stat_reject_q != 16'hFFFF)) begin
                stat_reject_q <= stat_reject_q + 16'd1;
            end
            if (timeout_o && (stat_timeout_q != 16'hFFFF)) begin
                stat_timeout_q <= stat_timeout_q + 16'd1;
            end
        end
    end

    assign stat_commit_o  = stat_commit_q;
    assign stat_reject_o  = stat_reject_q;
    assign stat_timeout_o = stat_timeout_q;
`endif

endmodule
